// File: rtl/jtgng_sdram_pkg.sv
// rtl/jtgng_sdram_pkg.sv - shared constants, FSM encoding and round-robin pick for the ROM scheduler
package jtgng_sdram_pkg;

  localparam int AW_DEF = 22;
  localparam int DW_DEF = 32;
  localparam int SLOTS  = 4;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_ACK  = 2'd1;
  localparam logic [1:0] ST_WAIT_DATA = 2'd2;

  // First pending slot at or after ptr, ascending with wrap; ptr when nothing pends.
  function automatic logic [1:0] rr_pick(input logic [3:0] pend, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (pend[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/jtgng_rom_slot.sv
// rtl/jtgng_rom_slot.sv - one-entry cache per slot: tag, data, valid and the hit compare
module jtgng_rom_slot
  import jtgng_sdram_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          fill,
  input  logic          fill_valid,
  input  logic [AW-1:0] fill_tag,
  input  logic [DW-1:0] fill_data,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  output logic          ok,
  output logic          pending,
  output logic [DW-1:0] dout
);

  logic [AW-1:0] tag;
  logic [DW-1:0] data;
  logic          valid;
  logic          hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag   <= '0;
      data  <= '0;
      valid <= 1'b0;
    end else if (fill) begin
      tag   <= fill_tag;
      data  <= fill_data;
      valid <= fill_valid;
    end else if (clr) begin
      valid <= 1'b0;
    end
  end

  assign hit     = valid && (tag == addr);
  assign ok      = cs && hit;
  assign pending = cs && !hit;
  assign dout    = data;

endmodule

// File: rtl/jtgng_rom_sched.sv
// rtl/jtgng_rom_sched.sv - four-slot ROM read scheduler with round-robin SDRAM arbitration
module jtgng_rom_sched
  import jtgng_sdram_pkg::*;
#(
  parameter int            AW      = AW_DEF,
  parameter int            DW      = DW_DEF,
  parameter logic [AW-1:0] OFFSET0 = '0,
  parameter logic [AW-1:0] OFFSET1 = '0,
  parameter logic [AW-1:0] OFFSET2 = '0,
  parameter logic [AW-1:0] OFFSET3 = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               downloading,
  input  logic               loop_rst,
  input  logic [3:0]         slot_cs,
  input  logic [4*AW-1:0]    slot_addr,
  output logic [3:0]         slot_ok,
  output logic [4*DW-1:0]    slot_dout,
  output logic [AW-1:0]      sdram_addr,
  output logic               sdram_req,
  input  logic               sdram_ack,
  input  logic               data_rdy,
  input  logic [DW-1:0]      data_read
);

  logic          rst_all;
  logic [1:0]    state, state_nx;
  logic [1:0]    win, rr_ptr, winner;
  logic [AW-1:0] cap_addr;
  logic [3:0]    pending;
  logic          issue, fill_en;
  logic [AW-1:0] addr_a [SLOTS];
  logic [AW-1:0] off_a  [SLOTS];

  assign rst_all = rst || loop_rst;
  assign off_a[0] = OFFSET0;
  assign off_a[1] = OFFSET1;
  assign off_a[2] = OFFSET2;
  assign off_a[3] = OFFSET3;
  assign winner   = rr_pick(pending, rr_ptr);

  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    assign addr_a[g] = slot_addr[g*AW +: AW];

    jtgng_rom_slot #(.AW(AW), .DW(DW)) u_slot (
      .clk        (clk),
      .rst        (rst_all),
      .clr        (downloading),
      .fill       (fill_en && (win == 2'(g))),
      .fill_valid (!downloading),
      .fill_tag   (cap_addr),
      .fill_data  (data_read),
      .cs         (slot_cs[g]),
      .addr       (addr_a[g]),
      .ok         (slot_ok[g]),
      .pending    (pending[g]),
      .dout       (slot_dout[g*DW +: DW])
    );
  end

  always_ff @(posedge clk) begin
    if (rst_all) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:      if (|pending && !downloading) state_nx = ST_WAIT_ACK;
      ST_WAIT_ACK:  if (sdram_ack)                state_nx = ST_WAIT_DATA;
      ST_WAIT_DATA: if (data_rdy)                 state_nx = ST_IDLE;
      default:                                    state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    issue   = (state == ST_IDLE) && |pending && !downloading;
    fill_en = (state == ST_WAIT_DATA) && data_rdy;
  end

  // The fill is tagged with the captured address, so a slot that moved on does not hit.
  always_ff @(posedge clk) begin
    if (rst_all) begin
      win        <= '0;
      rr_ptr     <= '0;
      cap_addr   <= '0;
      sdram_addr <= '0;
      sdram_req  <= 1'b0;
    end else begin
      if (issue) begin
        win        <= winner;
        cap_addr   <= addr_a[winner];
        sdram_addr <= addr_a[winner] + off_a[winner];
        sdram_req  <= 1'b1;
      end
      if ((state == ST_WAIT_ACK) && sdram_ack) sdram_req <= 1'b0;
      if (fill_en) rr_ptr <= win + 2'd1;
    end
  end

endmodule

// File: tb/tb_jtgng_rom_sched.sv
// tb/tb_jtgng_rom_sched.sv - scoreboard bench for the ROM scheduler
module tb_jtgng_rom_sched;

  localparam int AW = 22;
  localparam int DW = 32;
  localparam logic [AW-1:0] OFF1 = 22'h010000;
  localparam logic [AW-1:0] OFF2 = 22'h3FFFF0;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            downloading = 1'b0;
  logic            loop_rst = 1'b0;
  logic [3:0]      slot_cs = '0;
  logic [4*AW-1:0] slot_addr = '0;
  logic [3:0]      slot_ok;
  logic [4*DW-1:0] slot_dout;
  logic [AW-1:0]   sdram_addr;
  logic            sdram_req;
  logic            sdram_ack = 1'b0;
  logic            data_rdy = 1'b0;
  logic [DW-1:0]   data_read = '0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int            slot;
    logic [AW-1:0] addr;
  } exp_t;
  exp_t exp_q[$];
  logic [AW-1:0] last_addr;

  jtgng_rom_sched #(.AW(AW), .DW(DW), .OFFSET1(OFF1), .OFFSET2(OFF2)) dut (
    .clk         (clk),
    .rst         (rst),
    .downloading (downloading),
    .loop_rst    (loop_rst),
    .slot_cs     (slot_cs),
    .slot_addr   (slot_addr),
    .slot_ok     (slot_ok),
    .slot_dout   (slot_dout),
    .sdram_addr  (sdram_addr),
    .sdram_req   (sdram_req),
    .sdram_ack   (sdram_ack),
    .data_rdy    (data_rdy),
    .data_read   (data_read)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [AW-1:0] off_of(input int s);
    case (s)
      1:       return OFF1;
      2:       return OFF2;
      default: return '0;
    endcase
  endfunction

  function automatic logic [DW-1:0] dout_of(input int s);
    return slot_dout[s*DW +: DW];
  endfunction

  task automatic set_addr(input int s, input logic [AW-1:0] a);
    slot_addr[s*AW +: AW] = a;
  endtask

  task automatic expect_req(input int s, input logic [AW-1:0] a);
    exp_t e;
    e.slot = s;
    e.addr = a + off_of(s);
    exp_q.push_back(e);
  endtask

  task automatic request(input int s, input logic [AW-1:0] a);
    set_addr(s, a);
    slot_cs[s] = 1'b1;
    expect_req(s, a);
  endtask

  task automatic wait_req(output int s);
    exp_t e;
    int n = 0;
    s = 0;
    while (!sdram_req && n < 100) begin
      tick();
      n++;
    end
    check("req_seen", 64'(sdram_req), 64'd1);
    check("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
    last_addr = sdram_addr;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      s = e.slot;
      check("sdram_addr", 64'(sdram_addr), 64'(e.addr));
    end
  endtask

  task automatic do_ack(input int dly);
    repeat (dly) begin
      tick();
      check("req_held", 64'(sdram_req), 64'd1);
    end
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    check("req_drop", 64'(sdram_req), 64'd0);
  endtask

  task automatic do_data(input int dly, input logic [DW-1:0] d);
    repeat (dly) tick();
    data_read = d;
    data_rdy  = 1'b1;
    tick();
    data_rdy  = 1'b0;
  endtask

  task automatic serve(input int da, input int dd, input logic [DW-1:0] d);
    int s;
    wait_req(s);
    do_ack(da);
    do_data(dd, d);
    check("fill_ok", 64'(slot_ok[s]), 64'd1);
    check("fill_dout", 64'(dout_of(s)), 64'(d));
  endtask

  initial begin
    int s;
    repeat (3) tick();
    check("rst_ok", 64'(slot_ok), 64'd0);
    check("rst_req", 64'(sdram_req), 64'd0);
    check("rst_addr", 64'(sdram_addr), 64'd0);
    check("rst_dout", 64'(slot_dout), 64'd0);
    rst = 1'b0;
    tick();

    // Single miss then hit on slot 1
    request(1, 22'h000100);
    tick();
    check("miss_lat", 64'(sdram_req), 64'd1);
    wait_req(s);
    check("miss_addr", 64'(sdram_addr), 64'h10100);
    do_ack(2);
    check("ok_before_data", 64'(slot_ok[1]), 64'd0);
    do_data(3, 32'hDEADBEEF);
    check("miss_ok", 64'(slot_ok[1]), 64'd1);
    check("miss_dout", 64'(dout_of(1)), 64'hDEADBEEF);
    repeat (3) begin
      tick();
      check("hit_noreq", 64'(sdram_req), 64'd0);
      check("hit_ok", 64'(slot_ok[1]), 64'd1);
    end
    set_addr(1, 22'h000200);
    #1 check("other_addr_miss", 64'(slot_ok[1]), 64'd0);
    set_addr(1, 22'h000100);
    #1 check("hit_same_cycle", 64'(slot_ok[1]), 64'd1);
    slot_cs = '0;

    // Round robin from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) request(i, 22'h001000 + 22'(i));
    for (int i = 0; i < 4; i++) serve(1, 2, 32'hA0000000 + 32'(i));
    tick();
    check("rr_all_ok", 64'(slot_ok), 64'hF);
    request(0, 22'h002000);
    request(3, 22'h002003);
    serve(1, 1, 32'hB0000000);
    serve(1, 1, 32'hB0000003);
    check("rr2_all_ok", 64'(slot_ok), 64'hF);
    slot_cs = '0;
    tick();

    // Offset wraps modulo 2^AW
    request(2, 22'h000020);
    serve(1, 1, 32'h22222222);
    check("wrap_addr", 64'(last_addr), 64'h10);

    // Download during WAIT_DATA
    request(0, 22'h000300);
    wait_req(s);
    do_ack(1);
    downloading = 1'b1;
    tick();
    check("dl_clears_valid", 64'(slot_ok[2]), 64'd0);
    do_data(2, 32'h5555AAAA);
    check("dl_fill_invalid", 64'(slot_ok[0]), 64'd0);
    check("dl_fill_data", 64'(dout_of(0)), 64'h5555AAAA);
    repeat (4) begin
      tick();
      check("dl_noreq", 64'(sdram_req), 64'd0);
    end
    slot_cs[2] = 1'b0;
    expect_req(0, 22'h000300);
    downloading = 1'b0;
    tick();
    check("dl_release", 64'(sdram_req), 64'd1);
    serve(1, 1, 32'h30303030);

    // Address change during WAIT_DATA
    request(0, 22'h000400);
    wait_req(s);
    do_ack(1);
    set_addr(0, 22'h000500);
    expect_req(0, 22'h000500);
    do_data(1, 32'h44440000);
    check("chg_no_ok", 64'(slot_ok[0]), 64'd0);
    serve(1, 1, 32'h55550000);

    // loop_rst behaves like rst
    loop_rst = 1'b1;
    slot_cs = '0;
    tick();
    loop_rst = 1'b0;
    check("loop_rst_dout", 64'(dout_of(0)), 64'd0);
    check("loop_rst_req", 64'(sdram_req), 64'd0);

    // Reset during WAIT_ACK, late data ignored
    request(1, 22'h000600);
    wait_req(s);
    rst = 1'b1;
    slot_cs = '0;
    tick();
    rst = 1'b0;
    check("rst_mid_req", 64'(sdram_req), 64'd0);
    check("rst_mid_addr", 64'(sdram_addr), 64'd0);
    tick();
    do_data(0, 32'h66666666);
    tick();
    check("late_data_dout", 64'(dout_of(1)), 64'd0);
    check("late_data_req", 64'(sdram_req), 64'd0);
    slot_cs = 4'b0010;
    #1 check("late_data_ok", 64'(slot_ok[1]), 64'd0);
    slot_cs = '0;
    tick();

    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jtgng_rom_sched.md
JTGNG_ROM_SCHED -- requirements
Module: jtgng_rom_sched

Interface
REQ-001 Parameters (name, default, meaning):
- AW, 22, SDRAM word address width.
- DW, 32, read data width.
- OFFSET0..OFFSET3, 22'd0, per-slot base added to slot address.

REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  SDRAM-domain clock (clk_rom).
- rst  in  1  synchronous active-high reset.
- downloading  in  1  ROM load in progress.
- loop_rst  in  1  SDRAM init-loop reset.
- slot_cs  in  4  per-slot read request, level.
- slot_addr  in  4*AW  packed slot addresses; slot i at [i*AW +: AW].
- slot_ok  out  4  per-slot data valid.
- slot_dout  out  4*DW  packed per-slot cached data.
- sdram_addr  out  AW  address to SDRAM controller.
- sdram_req  out  1  read request, held until ack.
- sdram_ack  in  1  controller accepted request.
- data_rdy  in  1  one-cycle pulse, data_read valid.
- data_read  in  DW  SDRAM read word.

REQ-003 Clock and reset: one clock, clk; reset rst is synchronous and active-high.

Function
REQ-004 Per-slot cache state: one entry per slot: tag (AW), data (DW), valid (1).
REQ-005 Hit rule: slot_ok[i] = slot_cs[i] & valid[i] & (tag[i]==slot_addr[i]), combinational from registered state.
REQ-006 slot_dout[i] always presents data[i].
REQ-007 Pending rule: pending[i] = slot_cs[i] & ~hit[i].
REQ-008 FSM states: IDLE, WAIT_ACK, WAIT_DATA.
REQ-009 IDLE transition: if any pending and downloading=0, select winner, then next cycle:
- win register <= winner; cap_addr <= slot_addr[winner];
- sdram_addr <= slot_addr[winner]+OFFSETwinner (modulo 2^AW);
- sdram_req <= 1; state <= WAIT_ACK.
REQ-010 Arbitration: round-robin. Search starts at rr_ptr, ascending, wrapping 3->0. rr_ptr <= winner+1 (mod 4) on completion.
REQ-011 WAIT_ACK: on sdram_ack, sdram_req <= 0, state <= WAIT_DATA. data_rdy in WAIT_ACK is ignored.
REQ-012 WAIT_DATA completion, on data_rdy:
- data[win] <= data_read; tag[win] <= cap_addr; valid[win] <= ~downloading;
- state <= IDLE.
REQ-013 Latency: cache hit -> slot_ok same cycle. Miss -> sdram_req rises 1 cycle after cs. slot_ok rises 1 cycle after data_rdy, if address unchanged.
REQ-014 Address change mid-transaction: fill still stored under cap_addr. No slot_ok unless the address matches. The new address re-requests from IDLE.
REQ-015 Back-to-back requests: minimum 1 IDLE cycle between data_rdy and next sdram_req.
REQ-016 Slot drops cs mid-transaction: transaction completes and fills the cache normally.
REQ-017 Downloading=1:
- all valid <= 0 every cycle;
- no new request leaves IDLE;
- an in-flight transaction completes, not marked valid.
REQ-018 loop_rst=1: identical effect to rst.

Reset
REQ-019 On rst or loop_rst, next edge:
- state=IDLE; sdram_req=0; sdram_addr=0;
- all valid=0, tag=0, data=0 (slot_ok=0, slot_dout=0);
- rr_ptr=0; win=0; cap_addr=0.
REQ-020 Reset mid-transaction abandons it. Late data_rdy after reset is ignored, since the FSM is in IDLE.

Structure
REQ-021 Package jtgng_sdram_pkg holds:
- FSM state encoding (2-bit localparams);
- default AW/DW;
- slot count constant 4.
REQ-022 Sub-module jtgng_rom_slot holds tag, data, valid and the hit compare; instantiated 4 times.
REQ-023 Arbiter, FSM and offset adders live in jtgng_rom_sched.

Verification
REQ-024 Single miss:
- Stimulus: slot1 cs, addr 0x00100, OFFSET1=0x10000; ack 2 cycles later, data_rdy 3 cycles after ack with 0xDEADBEEF.
- Response: sdram_addr=0x10100; slot_ok[1]=1 one cycle after data_rdy; slot_dout1=0xDEADBEEF.
REQ-025 Hit:
- Stimulus: repeat slot1 addr 0x00100 after REQ-024.
- Response: slot_ok[1]=1 same cycle; sdram_req stays 0.
REQ-026 Round-robin:
- Stimulus: all 4 slots miss simultaneously from reset.
- Response: service order 0,1,2,3. Then slot0 and slot3 missing again with rr_ptr=0 -> slot0 first, then slot3.
REQ-027 Wrap:
- Stimulus: OFFSET2=0x3FFFF0, slot2 addr 0x000020.
- Response: sdram_addr=0x000010.
REQ-028 Download:
- Stimulus: raise downloading during WAIT_DATA.
- Response: fill completes; valid stays 0; no sdram_req while downloading=1; the request issues 1 cycle after downloading falls.
REQ-029 Mid-transaction address change and reset:
- Stimulus: slot0 changes address during WAIT_DATA.
- Response: no slot_ok, then re-request.
- Stimulus: assert rst during WAIT_ACK.
- Response: sdram_req=0 next cycle; subsequent data_rdy ignored.
